// File: rtl/servo_ipd_pwm_pkg.sv
// Shared types and helpers for the servo_ipd_pwm I-PD position loop.
package servo_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ERR,
      MP,
      MI,
      MD,
      SUM,
      DONE
   } state_e;

   localparam int unsigned PWM_W_DEFAULT = 8;
   localparam int unsigned MID_DUTY      = 1 << (PWM_W_DEFAULT - 1);

   // Symmetric clamp to +/-(2^(width-1)-1); the most negative code is never produced.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned        width);
      logic signed [63:0] lim;
      lim = (64'sd1 <<< (width - 1)) - 64'sd1;
      if (value > lim) begin
         return lim;
      end else if (value < -lim) begin
         return -lim;
      end
      return value;
   endfunction

endpackage

// File: rtl/servo_ipd_pwm_if.sv
// Sample/setpoint/gain bus from the SPI ADC side into the servo loop.
interface servo_ipd_pwm_if #(
   parameter int REF_W  = 8,
   parameter int ADC_W  = 12,
   parameter int GAIN_W = 16
);
   logic [REF_W-1:0]  ref_pos;
   logic [ADC_W-1:0]  adc_data;
   logic              adc_valid;
   logic [GAIN_W-1:0] kp;
   logic [GAIN_W-1:0] ki;
   logic [GAIN_W-1:0] kd;

   modport master (output ref_pos, adc_data, adc_valid, kp, ki, kd);
   modport slave  (input  ref_pos, adc_data, adc_valid, kp, ki, kd);
endinterface

// File: rtl/servo_ipd_pwm_pwm_gen.sv
// PWM output stage: prescaler, PWM_W-bit counter, duty double-buffered at the counter wrap.
module servo_pwm_gen
   import servo_pkg::*;
#(
   parameter int PWM_W    = 8,
   parameter int PRESCALE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PWM_W-1:0] duty_pend_i,
   output logic [PWM_W-1:0] duty_o,
   output logic             pwm_o
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PWM_W-1:0] MID     = {1'b1, {(PWM_W-1){1'b0}}};

   logic [PS_W-1:0]  presc_q, presc_d;
   logic [PWM_W-1:0] cnt_q, cnt_d;
   logic [PWM_W-1:0] duty_q, duty_d;
   logic             pwm_q, pwm_d;
   logic             tick;

   always_comb begin
      tick    = (presc_q == PS_LAST);
      presc_d = tick ? '0 : presc_q + 1'b1;
      cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
      duty_d  = (tick && (cnt_q == '1)) ? duty_pend_i : duty_q;
      // Registered compare so the pin is low out of reset.
      pwm_d   = (cnt_d < duty_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         cnt_q   <= '0;
         duty_q  <= MID;
         pwm_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
      end
   end

   assign duty_o = duty_q;
   assign pwm_o  = pwm_q;

endmodule

// File: rtl/servo_ipd_pwm.sv
// I-PD position loop with one time-multiplexed multiplier feeding a PWM stage.
// Optional SERVO_DEADBAND_EN adds deadband_i, holding the integrator for small errors.
module servo_ipd_pwm
   import servo_pkg::*;
#(
   parameter int REF_W    = 8,
   parameter int ADC_W    = 12,
   parameter int GAIN_W   = 16,
   parameter int FRAC     = 8,
   parameter int ACC_W    = 24,
   parameter int PWM_W    = 8,
   parameter int PRESCALE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   servo_ipd_pwm_if.slave   bus,
`ifdef SERVO_DEADBAND_EN
   input  logic [ADC_W-1:0] deadband_i,
`endif
   output logic             pwm_o,
   output logic [PWM_W-1:0] duty_o,
   output logic             duty_valid_o,
   output logic             busy_o,
   output logic             sat_o,
   output logic             overrun_o
);

   localparam int SH     = ADC_W - PWM_W;
   localparam int PROD_W = GAIN_W + ACC_W + 1;
   localparam logic [PWM_W-1:0] MID    = {1'b1, {(PWM_W-1){1'b0}}};
   localparam logic signed [63:0] MID_S  = 64'sd1 <<< (PWM_W - 1);
   localparam logic signed [63:0] VMAX_S = (64'sd1 <<< PWM_W) - 64'sd1;

   state_e                   state_q, state_d;
   logic [ADC_W-1:0]         y_q, y_d, ref_q, ref_d, yprev_q, yprev_d;
   logic [GAIN_W-1:0]        kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
   logic signed [ACC_W-1:0]  integ_q, integ_d, integ_old_q, integ_old_d, acc_q, acc_d;
   logic [PWM_W-1:0]         v_q, v_d, pend_q, pend_d;
   logic                     sat_q, sat_d, ovr_q, ovr_d;
   logic                     busy, hold;
   logic signed [ADC_W:0]    err, dy;
   logic [GAIN_W-1:0]        gain_sel;
   logic signed [ACC_W-1:0]  mul_b, acc_shift;
   logic signed [PROD_W-1:0] prod, term;
   logic signed [63:0]       acc_sum, integ_sum, v_sum;

   assign busy = (state_q != IDLE) && (state_q != DONE);
   assign err  = $signed({1'b0, ref_q}) - $signed({1'b0, y_q});
   // y_prev - y, i.e. the negated derivative, so the multiplier only ever accumulates.
   assign dy   = $signed({1'b0, yprev_q}) - $signed({1'b0, y_q});

`ifdef SERVO_DEADBAND_EN
   logic [ADC_W:0] err_mag;
   assign err_mag = err[ADC_W] ? $unsigned(-err) : $unsigned(err);
   assign hold    = (err_mag <= {1'b0, deadband_i});
`else
   assign hold    = 1'b0;
`endif

   always_comb begin
      gain_sel = kp_q;
      mul_b    = '0;
      case (state_q)
         MP: begin
            gain_sel = kp_q;
            mul_b    = -ACC_W'($signed({1'b0, y_q}));
         end
         MI: begin
            gain_sel = ki_q;
            mul_b    = integ_q;
         end
         MD: begin
            gain_sel = kd_q;
            mul_b    = ACC_W'(dy);
         end
         default: ;
      endcase
      prod = PROD_W'($signed({1'b0, gain_sel})) * PROD_W'(mul_b);
      term = prod >>> FRAC;
   end

   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      ref_d       = ref_q;
      yprev_d     = yprev_q;
      kp_d        = kp_q;
      ki_d        = ki_q;
      kd_d        = kd_q;
      integ_d     = integ_q;
      integ_old_d = integ_old_q;
      acc_d       = acc_q;
      v_d         = v_q;
      pend_d      = pend_q;
      sat_d       = sat_q;
      ovr_d       = ovr_q;
      acc_sum     = ((state_q == MP) ? 64'sd0 : 64'(acc_q)) + 64'(term);
      integ_sum   = 64'(integ_q) + 64'(err);
      acc_shift   = acc_q >>> SH;
      v_sum       = 64'(acc_shift) + MID_S;

      case (state_q)
         IDLE: begin
            if (bus.adc_valid) begin
               y_d     = bus.adc_data;
               ref_d   = ADC_W'(bus.ref_pos) << (ADC_W - REF_W);
               kp_d    = bus.kp;
               ki_d    = bus.ki;
               kd_d    = bus.kd;
               state_d = ERR;
            end
         end
         ERR: begin
            integ_old_d = integ_q;
            if (!hold) begin
               integ_d = ACC_W'(sat_signed(integ_sum, ACC_W));
            end
            state_d = MP;
         end
         MP, MI: begin
            acc_d   = ACC_W'(sat_signed(acc_sum, ACC_W));
            state_d = (state_q == MP) ? MI : MD;
         end
         MD: begin
            acc_d   = ACC_W'(sat_signed(acc_sum, ACC_W));
            yprev_d = y_q;
            state_d = SUM;
         end
         SUM: begin
            sat_d = 1'b1;
            if (v_sum < 64'sd0) begin
               v_d = '0;
            end else if (v_sum > VMAX_S) begin
               v_d = '1;
            end else begin
               v_d   = PWM_W'(v_sum);
               sat_d = 1'b0;
            end
            // Anti-windup: a clamped output discards this sample's integrator step.
            if (sat_d) begin
               integ_d = integ_old_q;
            end
            state_d = DONE;
         end
         DONE: begin
            pend_d  = v_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (bus.adc_valid && busy) begin
         ovr_d = 1'b1;
      end

      if (!enable_i) begin
         state_d = IDLE;
         integ_d = '0;
         pend_d  = MID;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         integ_q <= '0;
         yprev_q <= '0;
         pend_q  <= MID;
         sat_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         integ_q <= integ_d;
         yprev_q <= yprev_d;
         pend_q  <= pend_d;
         sat_q   <= sat_d;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge clk) begin
      y_q         <= y_d;
      ref_q       <= ref_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      kd_q        <= kd_d;
      integ_old_q <= integ_old_d;
      acc_q       <= acc_d;
      v_q         <= v_d;
   end

   servo_pwm_gen #(
      .PWM_W    (PWM_W),
      .PRESCALE (PRESCALE)
   ) u_pwm (
      .clk         (clk),
      .rst_n       (rst_n),
      .duty_pend_i (pend_q),
      .duty_o      (duty_o),
      .pwm_o       (pwm_o)
   );

   assign duty_valid_o = (state_q == DONE) && enable_i;
   assign busy_o       = busy;
   assign sat_o        = sat_q;
   assign overrun_o    = ovr_q;

endmodule
